// File: rtl/if_stage.sv
// if_stage: instruction fetch FSM plus IF/ID register with 1-entry skid buffer.
// Define IF_PERF_CNT_EN to add the o_fetchCnt delivered-instruction counter.
module if_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC = 16'd1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_redirect,
  input  logic [15:0] i_redirectPc,
  output logic        o_imemRd,
  output logic [15:0] o_imemAddr,
  input  logic [15:0] i_imemData,
  input  logic        i_imemValid,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  output logic        o_valid,
  output logic        o_hlt
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0] o_fetchCnt
`endif
);
  localparam logic [3:0] HLT_OP = 4'hF;
  typedef enum logic [1:0] {REQ, WAIT, HALTED} fsmState;
  fsmState state;
  logic [15:0] pc, reqAddr, skidInstr, skidPc;
  logic busy, dropFlag, skidValid;
  logic kill, resp, goodResp, loadSkid, loadResp, load, toSkid, skidNext, loadHlt, issue;
  logic [15:0] respPc, loadInstr, loadPc;
  // busy marks the single outstanding request; responses without one are ignored
  always_comb begin
    kill = i_flush || i_redirect;
    resp = i_imemValid && busy;
    goodResp = resp && !dropFlag && !kill;
    loadSkid = !kill && !i_stall && skidValid;
    loadResp = !kill && !i_stall && !skidValid && goodResp;
    load = loadSkid || loadResp;
    toSkid = goodResp && i_stall;
    respPc = reqAddr + PC_INC;
    loadInstr = loadSkid ? skidInstr : i_imemData;
    loadPc = loadSkid ? skidPc : respPc;
    loadHlt = load && loadInstr[15:12] == HLT_OP;
    skidNext = toSkid || (skidValid && !kill && !loadSkid);
    issue = state == REQ ? !i_redirect
          : state == WAIT && !i_redirect && (!busy || resp) && !skidNext && !loadHlt;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= REQ;
      pc <= RESET_PC;
      reqAddr <= 16'h0000;
      busy <= 1'b0;
      dropFlag <= 1'b0;
      skidValid <= 1'b0;
      skidInstr <= 16'h0000;
      skidPc <= 16'h0000;
      o_imemRd <= 1'b0;
      o_imemAddr <= 16'h0000;
      o_instr <= 16'h0000;
      o_pc <= 16'h0000;
      o_valid <= 1'b0;
      o_hlt <= 1'b0;
    end else begin
      o_imemRd <= issue;
      o_imemAddr <= issue ? pc : 16'h0000;
      if (issue) reqAddr <= pc;
      pc <= i_redirect ? i_redirectPc : issue ? pc + PC_INC : pc;
      busy <= issue || (busy && !resp);
      dropFlag <= busy && !resp && (i_redirect || dropFlag);
      o_valid <= load || (o_valid && i_stall && !kill);
      if (load) begin
        o_instr <= loadInstr;
        o_pc <= loadPc;
      end
      skidValid <= skidNext;
      if (toSkid) begin
        skidInstr <= i_imemData;
        skidPc <= respPc;
      end
      o_hlt <= !i_redirect && (o_hlt || loadHlt);
      state <= i_redirect ? (busy && !resp ? WAIT : REQ) : loadHlt ? HALTED : issue ? WAIT : state;
    end
  end
`ifdef IF_PERF_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) o_fetchCnt <= 16'h0000;
    else if (load) o_fetchCnt <= o_fetchCnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized and directed checks of if_stage against a transaction-level
// model of the fetch stream, memory and IF/ID contents.
module tb_if_stage;
  typedef struct packed {logic [15:0] instr; logic [15:0] pc;} ent_t;
  logic clk = 0, rst = 1, stall = 0, flush = 0, redir = 0;
  logic [15:0] redirPc = 0, imemData = 0;
  logic imemValid = 0;
  logic imemRd, valid, hlt;
  logic [15:0] imemAddr, instr, pc;
`ifdef IF_PERF_CNT_EN
  logic [15:0] fetchCnt;
`endif
  int errors = 0, checks = 0, cyc = 0, loads = 0, reqs = 0, reqErr = 0;
  int latMin = 1, latMax = 1, respCycle = 0;
  bit pend = 0, pendDrop = 0;
  logic [15:0] pendAddr = 0, modelPc = 0, hltAddr = 16'hFFFF;
  logic expValid = 0, expHlt = 0;
  logic [15:0] expInstr = 0, expPc = 0, expCnt = 0;
  ent_t expQ[$];

  always #5 clk = ~clk;

  if_stage dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush), .i_redirect(redir),
    .i_redirectPc(redirPc), .o_imemRd(imemRd), .o_imemAddr(imemAddr),
    .i_imemData(imemData), .i_imemValid(imemValid), .o_instr(instr), .o_pc(pc),
    .o_valid(valid), .o_hlt(hlt)
`ifdef IF_PERF_CNT_EN
    , .o_fetchCnt(fetchCnt)
`endif
  );

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return a == hltAddr ? 16'hF000 : {1'b0, a[2:0], a[11:0]};
  endfunction

  // One clock: memory model drives its response, then the expected IF/ID state,
  // skid contents and fetch address stream are advanced from the cycle's inputs.
  task automatic step();
    logic mv, rg, ld;
    logic [15:0] md;
    ent_t e;
    mv = pend && cyc == respCycle;
    md = memWord(pendAddr);
    imemValid = mv;
    imemData = mv ? md : 16'($urandom);
    @(posedge clk); #1;
    cyc++;
    reqErr = 0;
    if (mv) pend = 0;
    if (rst) begin
      if (pend) pendDrop = 1;
      modelPc = 0; expQ.delete(); expValid = 0; expInstr = 0; expPc = 0; expHlt = 0; expCnt = 0;
    end else begin
      rg = mv && !pendDrop && !(flush || redir);
      if (redir && pend) pendDrop = 1;
      if (flush || redir) begin
        expQ.delete();
        expValid = 0;
        if (redir) begin modelPc = redirPc; expHlt = 0; end
      end else if (!stall) begin
        ld = 0;
        if (expQ.size() > 0) begin e = expQ.pop_front(); ld = 1; end
        else if (rg) begin e.instr = md; e.pc = pendAddr + 16'd1; ld = 1; end
        expValid = ld;
        if (ld) begin
          expInstr = e.instr; expPc = e.pc; expCnt++; loads++;
          if (e.instr[15:12] == 4'hF) expHlt = 1;
        end
      end else if (rg) begin
        e.instr = md; e.pc = pendAddr + 16'd1;
        expQ.push_back(e);
      end
    end
    if (imemRd) begin
      reqs++;
      if (imemAddr !== modelPc || pend || expHlt || expQ.size() != 0) reqErr = 1;
      modelPc = modelPc + 16'd1;
      pend = 1; pendDrop = 0; pendAddr = imemAddr;
      respCycle = cyc + $urandom_range(latMin, latMax);
    end else if (imemAddr !== 16'h0000) reqErr = 2;
    if (expQ.size() > 1) reqErr = 3;
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if ({valid, instr, pc, hlt, imemRd, imemAddr} !== 51'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b i=%h pc=%h h=%b rd=%b a=%h want all zero", valid, instr, pc, hlt, imemRd, imemAddr);
    end
    rst = 0;
    step();
    checks++;
    if (imemRd !== 1'b1 || imemAddr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_first_req got rd=%b addr=%h want rd=1 addr=0000", imemRd, imemAddr);
    end
  endtask

  task automatic test_stream();
    logic [15:0] seen[$];
    int l0;
    latMin = 1; latMax = 1; l0 = loads;
    for (int i = 0; i < 40; i++) begin
      step();
      if (valid === 1'b1) seen.push_back(pc);
      checks++;
      if ({valid, instr, pc, hlt} !== {expValid, expInstr, expPc, expHlt}) begin
        errors++;
        $display("FAIL stream_ifid@%0d got v=%b i=%h pc=%h h=%b want v=%b i=%h pc=%h h=%b", cyc, valid, instr, pc, hlt, expValid, expInstr, expPc, expHlt);
      end
      checks++;
      if (reqErr !== 0) begin errors++; $display("FAIL stream_req@%0d code=%0d addr=%h want code 0 addr %h", cyc, reqErr, imemAddr, modelPc); end
    end
    checks++;
    if (seen.size() < 3 || seen[0] !== 16'd1 || seen[1] !== 16'd2 || seen[2] !== 16'd3) begin
      errors++;
      $display("FAIL stream_pcs got %0d loads first=%h want pcs 0001,0002,0003", seen.size(), seen.size() > 0 ? seen[0] : 16'hxxxx);
    end
    checks++;
    if (loads - l0 < 15) begin errors++; $display("FAIL stream_rate got %0d loads want >=15", loads - l0); end
  endtask

  task automatic test_stall();
    int n;
    latMin = 1; latMax = 1; n = 0;
    while (!imemRd && n < 10) begin step(); n++; end
    checks++;
    if (imemRd !== 1'b1) begin errors++; $display("FAIL stall_wait_req got rd=%b want 1", imemRd); end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({valid, instr, pc, imemRd} !== {expValid, expInstr, expPc, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold@%0d got v=%b i=%h pc=%h rd=%b want v=%b i=%h pc=%h rd=0", cyc, valid, instr, pc, imemRd, expValid, expInstr, expPc);
      end
    end
    checks++;
    if (expQ.size() != 1) begin errors++; $display("FAIL stall_skid_model got %0d entries want 1", expQ.size()); end
    stall = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if ({valid, instr, pc, hlt} !== {expValid, expInstr, expPc, expHlt}) begin
        errors++;
        $display("FAIL stall_ifid@%0d got v=%b i=%h pc=%h h=%b want v=%b i=%h pc=%h h=%b", cyc, valid, instr, pc, hlt, expValid, expInstr, expPc, expHlt);
      end
      checks++;
      if (reqErr !== 0) begin errors++; $display("FAIL stall_req@%0d code=%0d addr=%h want code 0 addr %h", cyc, reqErr, imemAddr, modelPc); end
    end
  endtask

  task automatic test_redirect();
    int n;
    latMin = 3; latMax = 3;
    redir = 1; redirPc = 16'h0005; step(); redir = 0;
    n = 0;
    while (!(imemRd && imemAddr == 16'h0005) && n < 12) begin step(); n++; end
    checks++;
    if (imemRd !== 1'b1 || imemAddr !== 16'h0005) begin errors++; $display("FAIL redir_req5 got rd=%b addr=%h want rd=1 addr=0005", imemRd, imemAddr); end
    redir = 1; redirPc = 16'h0040; step(); redir = 0;
    n = 0;
    while (!imemRd && n < 12) begin
      step(); n++;
      checks++;
      if (valid !== 1'b0) begin errors++; $display("FAIL redir_bubble@%0d got v=%b want 0", cyc, valid); end
    end
    checks++;
    if (imemRd !== 1'b1 || imemAddr !== 16'h0040) begin errors++; $display("FAIL redir_target got rd=%b addr=%h want rd=1 addr=0040", imemRd, imemAddr); end
    n = 0;
    while (!valid && n < 8) begin step(); n++; end
    checks++;
    if ({valid, instr, pc} !== {1'b1, memWord(16'h0040), 16'h0041}) begin
      errors++;
      $display("FAIL redir_deliver got v=%b i=%h pc=%h want v=1 i=%h pc=0041", valid, instr, pc, memWord(16'h0040));
    end
  endtask

  task automatic test_hlt();
    int n;
    latMin = 1; latMax = 1; hltAddr = 16'h0003;
    redir = 1; redirPc = 16'h0000; step(); redir = 0;
    n = 0;
    while (!(valid && pc == 16'h0004) && n < 30) begin step(); n++; end
    checks++;
    if ({valid, instr, pc, hlt} !== {1'b1, 16'hF000, 16'h0004, 1'b1}) begin
      errors++;
      $display("FAIL hlt_deliver got v=%b i=%h pc=%h h=%b want v=1 i=f000 pc=0004 h=1", valid, instr, pc, hlt);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (imemRd !== 1'b0 || hlt !== 1'b1) begin errors++; $display("FAIL hlt_idle@%0d got rd=%b h=%b want rd=0 h=1", cyc, imemRd, hlt); end
    end
    redir = 1; redirPc = 16'h0010; step(); redir = 0;
    checks++;
    if (hlt !== 1'b0) begin errors++; $display("FAIL hlt_clear got h=%b want 0", hlt); end
    n = 0;
    while (!imemRd && n < 6) begin step(); n++; end
    checks++;
    if (imemRd !== 1'b1 || imemAddr !== 16'h0010) begin errors++; $display("FAIL hlt_resume got rd=%b addr=%h want rd=1 addr=0010", imemRd, imemAddr); end
    hltAddr = 16'hFFFF;
  endtask

  task automatic test_flush_stall();
    int n;
    latMin = 1; latMax = 1;
    redir = 1; redirPc = 16'h0020; step(); redir = 0;
    n = 0;
    while (!valid && n < 10) begin step(); n++; end
    while (!imemRd && n < 20) begin step(); n++; end
    stall = 1; step(); step();
    checks++;
    if (expQ.size() != 1 || valid !== 1'b1) begin errors++; $display("FAIL fs_setup got skid=%0d v=%b want skid=1 v=1", expQ.size(), valid); end
    flush = 1; step(); flush = 0;
    checks++;
    if (valid !== 1'b0 || instr !== expInstr) begin errors++; $display("FAIL fs_flush got v=%b i=%h want v=0 i=%h", valid, instr, expInstr); end
    stall = 0; step();
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL fs_skid_empty got v=%b want 0", valid); end
  endtask

  task automatic test_reset_wait();
    int n;
    latMin = 3; latMax = 3;
    redir = 1; redirPc = 16'h0030; step(); redir = 0;
    n = 0;
    while (!imemRd && n < 10) begin step(); n++; end
    step();
    rst = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({valid, instr, pc, hlt, imemRd, imemAddr} !== 51'd0) begin
        errors++;
        $display("FAIL rstwait_outputs@%0d got v=%b i=%h pc=%h h=%b rd=%b a=%h want all zero", cyc, valid, instr, pc, hlt, imemRd, imemAddr);
      end
    end
    rst = 0; step();
    checks++;
    if (imemRd !== 1'b1 || imemAddr !== 16'h0000) begin errors++; $display("FAIL rstwait_req got rd=%b addr=%h want rd=1 addr=0000", imemRd, imemAddr); end
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if ({valid, instr, pc, hlt} !== {expValid, expInstr, expPc, expHlt}) begin
        errors++;
        $display("FAIL rstwait_ifid@%0d got v=%b i=%h pc=%h h=%b want v=%b i=%h pc=%h h=%b", cyc, valid, instr, pc, hlt, expValid, expInstr, expPc, expHlt);
      end
    end
  endtask

  task automatic test_random();
    int l0;
    latMin = 1; latMax = 3; hltAddr = 16'h0013; l0 = loads;
    for (int i = 0; i < 800; i++) begin
      stall = $urandom_range(0, 99) < 25;
      flush = $urandom_range(0, 99) < 4;
      redir = $urandom_range(0, 99) < 5;
      redirPc = 16'($urandom_range(0, 31));
      step();
      checks++;
      if ({valid, instr, pc, hlt} !== {expValid, expInstr, expPc, expHlt}) begin
        errors++;
        $display("FAIL rand_ifid@%0d got v=%b i=%h pc=%h h=%b want v=%b i=%h pc=%h h=%b", cyc, valid, instr, pc, hlt, expValid, expInstr, expPc, expHlt);
      end
      checks++;
      if (reqErr !== 0) begin errors++; $display("FAIL rand_req@%0d code=%0d addr=%h want code 0 addr %h", cyc, reqErr, imemAddr, modelPc); end
`ifdef IF_PERF_CNT_EN
      checks++;
      if (fetchCnt !== expCnt) begin errors++; $display("FAIL rand_cnt@%0d got %0d want %0d", cyc, fetchCnt, expCnt); end
`endif
    end
    stall = 0; flush = 0; redir = 0; hltAddr = 16'hFFFF;
    checks++;
    if (loads - l0 < 60) begin errors++; $display("FAIL rand_progress got %0d loads want >=60", loads - l0); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_hlt();
    test_flush_stall();
    test_reset_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
